pool1: RTL and testbench

ReLU plus 2×2 max-pool stage directly downstream of the first convolution layer in the MNIST accelerator. After the convolution stage finishes writing its 3-channel 24×24 feature map into the shared feature RAM, this block scans the map window by window. Each output is the maximum of four ReLU-clamped values. It writes a 3-channel 12×12 map into the pool RAM for the next layer, and holds `busy` high while it runs.

---
 rtl/pool1.sv | 182 ++++++++++++++++++
 tb/tb_pool1.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pool1.sv
// ReLU + 2x2 max-pool stage: scans a channel-major feature map window by window
// and writes one clamped maximum per window into the pool RAM.
module pool1 #(
  parameter int unsigned IN_W     = 24,
  parameter int unsigned IN_H     = 24,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DATA_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upstream_busy,
  input  logic [DATA_W-1:0] data_in,
  output logic [10:0]       raddr,
  output logic              ren,
  output logic [8:0]        waddr,
  output logic              wen,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
);

  localparam int unsigned OUT_W = IN_W / 2;
  localparam int unsigned OUT_H = IN_H / 2;
  localparam int unsigned MAP   = IN_W * IN_H;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic              ub_d1_q;
  logic [3:0]        ch_q, ch_d;
  logic [3:0]        oy_q, oy_d;
  logic [3:0]        ox_q, ox_d;
  logic [1:0]        phase_q, phase_d;
  logic [10:0]       raddr_q, raddr_d;
  logic              ren_q, ren_d;
  logic [8:0]        waddr_q, waddr_d;
  logic [8:0]        wcnt_q, wcnt_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic              pend_q, pend_d;
  logic              busy_q, busy_d;

  logic              start;
  logic              last_issue;
  logic [DATA_W-1:0] relu;
  logic [31:0]       addr_calc;

  assign start      = ub_d1_q && !upstream_busy && (state_q == StIdle);
  assign last_issue = (phase_q == 2'd3) && (ox_q == 4'(OUT_W - 1)) &&
                      (oy_q == 4'(OUT_H - 1)) && (ch_q == 4'(CHANNELS - 1));
  assign relu       = data_in[DATA_W-1] ? '0 : data_in;

  // Read address of the window/phase about to be issued.
  assign addr_calc = 32'(ch_d) * MAP + 32'(oy_d) * (2 * IN_W) + 32'(ox_d) * 2 +
                     (phase_d[1] ? IN_W : 32'd0) + 32'(phase_d[0]);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    phase_d = phase_q;
    raddr_d = raddr_q;
    ren_d   = ren_q;
    busy_d  = busy_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          ch_d    = '0;
          oy_d    = '0;
          ox_d    = '0;
          phase_d = '0;
          ren_d   = 1'b1;
          raddr_d = 11'(addr_calc);
        end
      end
      StRun: begin
        if (last_issue) begin
          state_d = StDrain;
          ren_d   = 1'b0;
        end else begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (ox_q == 4'(OUT_W - 1)) begin
              ox_d = '0;
              if (oy_q == 4'(OUT_H - 1)) begin
                oy_d = '0;
                ch_d = ch_q + 4'd1;
              end else begin
                oy_d = oy_q + 4'd1;
              end
            end else begin
              ox_d = ox_q + 4'd1;
            end
          end
          raddr_d = 11'(addr_calc);
        end
      end
      StDrain: begin
        // The only write that can occur in DRAIN is the final one.
        if (wen_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // Return path: data for the read issued last cycle arrives now.
  always_comb begin
    max_d   = max_q;
    pend_d  = 1'b0;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    dout_d  = dout_q;
    wcnt_d  = wcnt_q;

    if (start) wcnt_d = '0;

    if (ren_q) begin
      if (phase_q == 2'd0) begin
        max_d = relu;
      end else if (relu > max_q) begin
        max_d = relu;
      end
      pend_d = (phase_q == 2'd3);
    end

    if (pend_q) begin
      wen_d   = 1'b1;
      waddr_d = wcnt_q;
      dout_d  = max_q;
      wcnt_d  = wcnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ub_d1_q <= 1'b0;
      ch_q    <= '0;
      oy_q    <= '0;
      ox_q    <= '0;
      phase_q <= '0;
      raddr_q <= '0;
      ren_q   <= 1'b0;
      waddr_q <= '0;
      wcnt_q  <= '0;
      wen_q   <= 1'b0;
      dout_q  <= '0;
      max_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ub_d1_q <= upstream_busy;
      ch_q    <= ch_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
      phase_q <= phase_d;
      raddr_q <= raddr_d;
      ren_q   <= ren_d;
      waddr_q <= waddr_d;
      wcnt_q  <= wcnt_d;
      wen_q   <= wen_d;
      dout_q  <= dout_d;
      max_q   <= max_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
    end
  end

  assign raddr    = raddr_q;
  assign ren      = ren_q;
  assign waddr    = waddr_q;
  assign wen      = wen_q;
  assign data_out = dout_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pool1.sv
// Bench for pool1: a combinational feature RAM model, per-frame trace capture and
// comparison against a window-max reference computed directly from the map.
module tb_pool1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upstream_busy;
  logic [11:0] data_in;
  logic [10:0] raddr;
  logic        ren;
  logic [8:0]  waddr;
  logic        wen;
  logic [11:0] data_out;
  logic        busy;

  logic [11:0] mem [0:1727];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  assign data_in = (raddr < 11'd1728) ? mem[raddr] : 12'd0;

  pool1 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .upstream_busy(upstream_busy),
    .data_in      (data_in),
    .raddr        (raddr),
    .ren          (ren),
    .waddr        (waddr),
    .wen          (wen),
    .data_out     (data_out),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] relu(input logic [11:0] v);
    return v[11] ? 12'd0 : v;
  endfunction

  // Max of the four clamped samples of output window n.
  function automatic logic [11:0] model_max(input int n);
    int ch, oy, ox, base;
    logic [11:0] m, s;
    ch   = n / 144;
    oy   = (n % 144) / 12;
    ox   = n % 12;
    base = ch * 576 + 2 * oy * 24 + 2 * ox;
    m    = 12'd0;
    for (int dy = 0; dy < 2; dy++) begin
      for (int dx = 0; dx < 2; dx++) begin
        s = relu(mem[base + dy * 24 + dx]);
        if (s > m) m = s;
      end
    end
    return m;
  endfunction

  function automatic int model_raddr(input int i);
    int n, p;
    n = i / 4;
    p = i % 4;
    return (n / 144) * 576 + 2 * ((n % 144) / 12) * 24 + 2 * (n % 12) + (p / 2) * 24 + (p % 2);
  endfunction

  // Produce a falling edge of upstream_busy; returns right after edge k (plus #1).
  task automatic start_edge();
    @(posedge clk); #1 upstream_busy = 1'b1;
    @(posedge clk); #1 upstream_busy = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input string name, input int glitch_at);
    int          rd_t[$];
    logic [10:0] rd_a[$];
    int          wr_t[$];
    logic [8:0]  wr_a[$];
    logic [11:0] wr_d[$];
    int          busy_cnt;
    int          nr, nw;
    busy_cnt = 0;
    start_edge();
    for (int t = 0; t < 1740; t++) begin
      if (ren) begin rd_t.push_back(t); rd_a.push_back(raddr); end
      if (wen) begin wr_t.push_back(t); wr_a.push_back(waddr); wr_d.push_back(data_out); end
      if (busy) busy_cnt++;
      if (t == 0) begin
        check({name, " busy_at_start"}, 32'(busy), 32'd1);
        check({name, " raddr_at_start"}, 32'(raddr), 32'd0);
      end
      if (t == 1727) check({name, " ren_last_read"}, 32'(ren), 32'd1);
      if (t == 1728) check({name, " ren_after_reads"}, 32'(ren), 32'd0);
      if (t == 1729) check({name, " busy_last_write"}, 32'(busy), 32'd1);
      if (t == 1730) begin
        check({name, " busy_end"}, 32'(busy), 32'd0);
        check({name, " wen_end"}, 32'(wen), 32'd0);
      end
      if (t == glitch_at) upstream_busy = 1'b1;
      if (t == glitch_at + 1) upstream_busy = 1'b0;
      @(posedge clk); #1;
    end
    check({name, " read_count"}, 32'(rd_a.size()), 32'd1728);
    nr = (rd_a.size() < 1728) ? rd_a.size() : 1728;
    for (int i = 0; i < nr; i++) begin
      check({name, " raddr"}, 32'(rd_a[i]), 32'(model_raddr(i)));
      check({name, " read_cycle"}, 32'(rd_t[i]), 32'(i));
    end
    check({name, " write_count"}, 32'(wr_a.size()), 32'd432);
    nw = (wr_a.size() < 432) ? wr_a.size() : 432;
    for (int n = 0; n < nw; n++) begin
      check({name, " waddr"}, 32'(wr_a[n]), 32'(n));
      check({name, " data_out"}, 32'(wr_d[n]), 32'(model_max(n)));
      check({name, " write_cycle"}, 32'(wr_t[n]), 32'(4 * n + 5));
    end
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'd1730);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1728; i++) mem[i] = 12'($urandom);
  endtask

  initial begin
    int wen_seen, busy_seen;
    logic [11:0] w0 [4];
    rst_n         = 1'b0;
    upstream_busy = 1'b0;
    for (int i = 0; i < 1728; i++) mem[i] = 12'd0;
    #1;
    check("reset raddr", 32'(raddr), 32'd0);
    check("reset ren", 32'(ren), 32'd0);
    check("reset wen", 32'(wen), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // Low upstream_busy at reset release must not start the block.
    repeat (20) @(posedge clk);
    #1;
    check("idle busy", 32'(busy), 32'd0);
    check("idle ren", 32'(ren), 32'd0);

    for (int i = 0; i < 1728; i++) mem[i] = 12'd100;
    run_frame("const100", -10);

    for (int i = 0; i < 1728; i++) mem[i] = 12'hF00;
    run_frame("negative", -10);

    // Window 0 pattern with the maximum rotated through all four positions.
    for (int r = 0; r < 4; r++) begin
      fill_random();
      w0[0] = 12'd5; w0[1] = 12'hFFD; w0[2] = 12'd2047; w0[3] = 12'd7;
      mem[(r + 0) % 4 == 0 ? 0 : ((r + 0) % 4 == 1 ? 1 : ((r + 0) % 4 == 2 ? 24 : 25))] = w0[0];
      mem[(r + 1) % 4 == 0 ? 0 : ((r + 1) % 4 == 1 ? 1 : ((r + 1) % 4 == 2 ? 24 : 25))] = w0[1];
      mem[(r + 2) % 4 == 0 ? 0 : ((r + 2) % 4 == 1 ? 1 : ((r + 2) % 4 == 2 ? 24 : 25))] = w0[2];
      mem[(r + 3) % 4 == 0 ? 0 : ((r + 3) % 4 == 1 ? 1 : ((r + 3) % 4 == 2 ? 24 : 25))] = w0[3];
      run_frame("window0", -10);
    end

    fill_random();
    run_frame("glitch", 100);

    // Reset in the middle of a run, then a full run after a fresh start edge.
    fill_random();
    start_edge();
    repeat (500) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst raddr", 32'(raddr), 32'd0);
    check("midrst ren", 32'(ren), 32'd0);
    check("midrst waddr", 32'(waddr), 32'd0);
    check("midrst wen", 32'(wen), 32'd0);
    check("midrst data_out", 32'(data_out), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wen_seen  = 0;
    busy_seen = 0;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk); #1;
      if (wen) wen_seen++;
      if (busy) busy_seen++;
    end
    check("postrst wen_pulses", 32'(wen_seen), 32'd0);
    check("postrst busy_cycles", 32'(busy_seen), 32'd0);
    run_frame("after_reset", -10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
